mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store initiator between the CPU datapath and a word-wide data memory.
- Accepts one byte/half/word load or store per request.
- Drives a word-aligned memory request/acknowledge handshake.
- Does read-modify-write for sub-word stores; lane extraction and zero/sign extension for loads.
- Flags misaligned accesses without touching memory.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting on mem_ack before abort (only with MAU_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  unit idle, request accepted when req_valid & req_ready
req_wr  in  1  1 store, 0 load
req_op  in  2  MemOp: `MEM_BYTE=2'd0, `MEM_HALF=2'd1, `MEM_WORD=2'd2 (2'd3 illegal)
req_ext  in  1  load extension: 0 zero, 1 sign
req_addr  in  32  byte address
req_wdata  in  32  store data, low bits used for byte/half
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data, valid with resp_valid (0 for stores)
resp_err  out  1  misaligned/illegal op (or timeout), valid with resp_valid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 write, 0 read
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wdata  out  32  full merged word
mem_ack  in  1  memory completes current request this cycle
mem_rdata  in  32  read word, valid when mem_ack & !mem_we

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- All outputs are registered. The accepted request (wr, op, ext, addr, wdata) is latched at handshake.
- FSM states: IDLE, RD, WR, RESP. req_ready=1 only in IDLE.
- IDLE, on accept:
  - Misaligned (HALF with addr[0]=1, WORD with addr[1:0]!=0) or op=3 -> RESP with err=1. No mem_req.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RD, then WR (read-modify-write).
- RD: mem_req=1, mem_we=0. On mem_ack, latch mem_rdata.
  - Load -> RESP: rdata = extract + extend. Byte lane = addr[1:0]; half lane = addr[1].
  - Store -> WR: mem_wdata = read word with the target lane replaced by req_wdata[7:0] or [15:0].
- WR: mem_req=1, mem_we=1. On mem_ack -> RESP, rdata=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The next request can be accepted the cycle after RESP.
- mem_req, mem_we, mem_addr, mem_wdata are stable while mem_req=1 and not acked. mem_req deasserts the cycle after mem_ack.
- Latency with zero-wait memory (ack in first cycle of mem_req):
  - Load or word store: resp_valid 2 cycles after accept.
  - RMW store: 3 cycles.
  - Misaligned: 1 cycle.
- req_valid while not ready: ignored. The CPU holds the request.
- mem_ack outside RD/WR: ignored.
- rst mid-transaction: immediate return to reset values; the in-flight access is abandoned with no response.

Optional Feature:
MAU_TIMEOUT_EN:
- Defined: a cycle counter clears on entering RD/WR and increments each cycle mem_req=1 without mem_ack.
  - On reaching TIMEOUT_CYCLES: drop mem_req, go to RESP with err=1, rdata=0.
  - For an RMW, no write is issued.
- Undefined: no counter; wait for mem_ack indefinitely.

Decomposition:
- Shared header ctrl_encode_def.v holds:
  - `MEM_BYTE/`MEM_HALF/`MEM_WORD
  - state encodings MAU_IDLE/MAU_RD/MAU_WR/MAU_RESP
- One combinational sub-module, mau_lane:
  - inputs: word, offset, op, ext, store data
  - outputs: extended load value and merged store word
- The FSM stays in mem_access_unit.

Test Plan:
- Word load, addr 0x0000_0008, mem_rdata 0xDEAD_BEEF, ack immediate -> mem_addr=0x8, mem_we=0; resp_rdata=0xDEADBEEF, err=0, 2 cycles after accept.
- Byte load signed, addr 0x...0B, word 0x80FF_1234 -> rdata 0xFFFF_FF80; same unsigned -> 0x0000_0080.
- Half store 0xABCD at addr 0x...06, prior word 0x1111_2222 -> RD then WR with mem_wdata=0xABCD_2222; resp_valid, err=0.
- Byte store 0x5A at addr 0x...01, prior 0x0000_0000, ack delayed 3 cycles per phase -> mem_wdata=0x0000_5A00; mem_* held stable during waits.
- Word load at addr 0x...02, and half load at 0x...03 -> resp_err=1 next cycle, mem_req never asserted.
- rst asserted during WR wait -> mem_req=0, req_ready=1 immediately, no resp_valid. With MAU_TIMEOUT_EN and no ack: err=1 after 16 cycles.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and encodings for the load/store memory access unit.
package mem_access_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_RD   = 2'd1,
    MAU_WR   = 2'd2,
    MAU_RESP = 2'd3
  } mau_state_t;

  // Request fields kept for the whole transaction; only the byte offset of the address is needed.
  typedef struct packed {
    logic            wr;
    logic [1:0]      op;
    logic            ext;
    logic [1:0]      off;
    logic [XLEN-1:0] wdata;
  } mau_req_t;

  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] off);
    case (op)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = off[0];
      MEM_WORD: is_misaligned = (off != 2'd0);
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte/half lane handling: load extraction with zero/sign extension and
// sub-word merge of store data into a read word.
module mau_lane
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_off,
  input  logic [1:0]      i_op,
  input  logic            i_ext,
  input  logic [XLEN-1:0] i_sdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_word[{i_off, 3'b000} +: 8];
    w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_load  = i_word;
    o_store = i_sdata;
    case (i_op)
      MEM_BYTE: begin
        o_load  = {{24{i_ext & w_byte[7]}}, w_byte};
        o_store = i_word;
        o_store[{i_off, 3'b000} +: 8] = i_sdata[7:0];
      end
      MEM_HALF: begin
        o_load  = {{16{i_ext & w_half[15]}}, w_half};
        o_store = i_word;
        if (i_off[1]) o_store[31:16] = i_sdata[15:0];
        else          o_store[15:0]  = i_sdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator to a word-wide memory with read-modify-write for sub-word stores.
// Optional MAU_TIMEOUT_EN aborts a memory phase after TIMEOUT_CYCLES cycles without mem_ack.
module mem_access_unit
  import mem_access_unit_pkg::*;
`ifdef MAU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [1:0]      req_op,
  input  logic            req_ext,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  mau_state_t      r_state;
  mau_req_t        r_req;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_store;
  logic            w_timeout;

  mau_lane u_lane (
    .i_word  (mem_rdata),
    .i_off   (r_req.off),
    .i_op    (r_req.op),
    .i_ext   (r_req.ext),
    .i_sdata (r_req.wdata),
    .o_load  (w_load),
    .o_store (w_store)
  );

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCNT_W-1:0] r_tcnt;

  // Counts unacknowledged request cycles; restarts for every new memory phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_tcnt <= '0;
    else if (!r_mem_req || mem_ack) r_tcnt <= '0;
    else                          r_tcnt <= r_tcnt + TCNT_W'(1);
  end

  assign w_timeout = r_mem_req && !mem_ack && (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= MAU_IDLE;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        MAU_IDLE: begin
          if (req_valid) begin
            r_req       <= '{wr: req_wr, op: req_op, ext: req_ext,
                             off: req_addr[1:0], wdata: req_wdata};
            r_req_ready <= 1'b0;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              r_state      <= MAU_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= {req_addr[XLEN-1:2], 2'b00};
              if (req_wr && (req_op == MEM_WORD)) begin
                r_state     <= MAU_WR;
                r_mem_we    <= 1'b1;
                r_mem_wdata <= req_wdata;
              end else begin
                r_state  <= MAU_RD;
                r_mem_we <= 1'b0;
              end
            end
          end
        end
        MAU_RD: begin
          if (mem_ack) begin
            if (r_req.wr) begin
              // Sub-word store: keep mem_req up and turn the read into the merged write.
              r_state     <= MAU_WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_store;
            end else begin
              r_state      <= MAU_RESP;
              r_mem_req    <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_load;
            end
          end else if (w_timeout) begin
            r_state      <= MAU_RESP;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end
        end
        MAU_WR: begin
          if (mem_ack || w_timeout) begin
            r_state      <= MAU_RESP;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !mem_ack;
            r_resp_rdata <= '0;
          end
        end
        MAU_RESP: begin
          r_state     <= MAU_IDLE;
          r_req_ready <= 1'b1;
        end
        default: r_state <= MAU_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a sparse word-memory model.
// Build with MAU_TIMEOUT_EN defined to also exercise the timeout abort.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic        req_ext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [logic [31:0]];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_op     (req_op),
    .req_ext    (req_ext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access: issue, act as memory, check response against the model.
  task automatic do_access(input string name, input bit wr, input logic [1:0] op,
                           input bit ext, input logic [31:0] addr, input logic [31:0] wdata,
                           input int d_rd, input int d_wr, input bit noise, input bit exp_tmo,
                           output logic [31:0] got_rdata, output logic [31:0] got_wword);
    logic [31:0] a, old_w, exp_rd, exp_new, mask, v, p_addr, p_wdata;
    logic [3:0]  ph_we, exp_we;
    logic        p_we;
    int          off, exp_lat, exp_nph, n_ph, t, wait_c;
    bit          mis, exp_err, done, acked_prev, prev_req, stab_bad, addr_bad, req_at_resp;

    a     = {addr[31:2], 2'b00};
    off   = int'(addr[1:0]);
    mis   = (op == 2'd3) || (op == 2'd1 && addr[0]) || (op == 2'd2 && addr[1:0] != 2'd0);
    if (!mem_m.exists(a)) mem_m[a] = $urandom;
    old_w = mem_m[a];
    mask  = (op == 2'd0) ? 32'h0000_00FF : (op == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    exp_err = mis;
    exp_rd  = '0;
    exp_new = old_w;
    exp_we  = 4'b0000;
    if (mis) begin
      exp_lat = 1; exp_nph = 0;
    end else if (!wr) begin
      v = (old_w >> (8 * off)) & mask;
      if (ext && op != 2'd2 && v[(op == 2'd0) ? 7 : 15]) v = v | ~mask;
      exp_rd = v; exp_lat = 2 + d_rd; exp_nph = 1;
    end else begin
      exp_new = (old_w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      if (op != 2'd2) begin
        exp_lat = 3 + d_rd + d_wr; exp_nph = 2; exp_we = 4'b0010;
      end else begin
        exp_lat = 2 + d_wr; exp_nph = 1; exp_we = 4'b0001;
      end
    end
    if (exp_tmo) begin
      exp_err = 1'b1; exp_rd = '0; exp_lat = TMO + 1; exp_nph = 0; exp_we = 4'b0000;
      exp_new = old_w;
    end

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_wr = wr; req_op = op; req_ext = ext; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = noise;

    t = 1; n_ph = 0; wait_c = 0; ph_we = '0; done = 0; acked_prev = 0; prev_req = 0;
    stab_bad = 0; addr_bad = 0; req_at_resp = 0; got_wword = '0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0;
    while (!done && t <= 80) begin
      if (resp_valid === 1'b1) begin
        done = 1; req_at_resp = mem_req; mem_ack = 1'b0; req_valid = 1'b0;
      end else begin
        if (mem_req === 1'b1) begin
          if (acked_prev) wait_c = 0;
          else if (prev_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
            stab_bad = 1;
          if (mem_addr !== a) addr_bad = 1;
          if (wait_c >= (mem_we ? d_wr : d_rd)) begin
            mem_ack = 1'b1;
            if (n_ph < 4) ph_we[n_ph] = mem_we;
            n_ph++;
            if (mem_we) begin
              got_wword = mem_wdata;
              mem_m[a]  = exp_new;
            end else begin
              mem_rdata = old_w;
            end
            acked_prev = 1;
          end else begin
            mem_ack = 1'b0; mem_rdata = $urandom; wait_c++; acked_prev = 0;
          end
          prev_req = 1; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        end else begin
          mem_ack = 1'b0; acked_prev = 0; prev_req = 0; wait_c = 0;
        end
        if (noise) begin
          req_wr = 1'($urandom_range(0, 1)); req_op = 2'($urandom); req_ext = 1'($urandom_range(0, 1));
          req_addr = $urandom; req_wdata = $urandom;
        end
        tick();
        t++;
      end
    end
    got_rdata = resp_rdata;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s no response within budget", name);
      rst = 1'b1; tick(); rst = 1'b0; mem_ack = 1'b0; req_valid = 1'b0;
    end
    checks++;
    if (t != exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, t, exp_lat); end
    checks++;
    if (resp_err !== exp_err) begin errors++; $display("FAIL %s err: got %b want %b", name, resp_err, exp_err); end
    checks++;
    if (resp_rdata !== exp_rd) begin errors++; $display("FAIL %s rdata: got %h want %h", name, resp_rdata, exp_rd); end
    checks++;
    if (n_ph != exp_nph || ph_we !== exp_we) begin
      errors++;
      $display("FAIL %s mem phases: got %0d/%b want %0d/%b", name, n_ph, ph_we, exp_nph, exp_we);
    end
    checks++;
    if (stab_bad || addr_bad) begin
      errors++;
      $display("FAIL %s mem bus: unstable %0d bad addr %0d want 0 0", name, stab_bad, addr_bad);
    end
    checks++;
    if (req_at_resp !== 1'b0) begin errors++; $display("FAIL %s mem_req at resp: got %b want 0", name, req_at_resp); end
    if (wr && !mis && !exp_tmo) begin
      checks++;
      if (got_wword !== exp_new) begin
        errors++;
        $display("FAIL %s wdata: got %h want %h", name, got_wword, exp_new);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks += 8;
    if (req_ready  !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    if (resp_err   !== 1'b0) begin errors++; $display("FAIL reset resp_err: got %b want 0", resp_err); end
    if (resp_rdata !== '0)   begin errors++; $display("FAIL reset resp_rdata: got %h want 0", resp_rdata); end
    if (mem_req    !== 1'b0) begin errors++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
    if (mem_we     !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
    if (mem_addr   !== '0)   begin errors++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
    if (mem_wdata  !== '0)   begin errors++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] r, w;
    mem_m[32'h0000_0008] = 32'hDEAD_BEEF;
    do_access("word_load", 0, 2'd2, 0, 32'h0000_0008, '0, 0, 0, 0, 0, r, w);
    checks++;
    if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load const: got %h want deadbeef", r); end
    mem_m[32'h0000_1008] = 32'h80FF_1234;
    do_access("byte_load_s", 0, 2'd0, 1, 32'h0000_100B, '0, 0, 0, 0, 0, r, w);
    checks++;
    if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_load_s const: got %h want ffffff80", r); end
    do_access("byte_load_u", 0, 2'd0, 0, 32'h0000_100B, '0, 0, 0, 0, 0, r, w);
    checks++;
    if (r !== 32'h0000_0080) begin errors++; $display("FAIL byte_load_u const: got %h want 00000080", r); end
    mem_m[32'h0000_2004] = 32'h1111_2222;
    do_access("half_store", 1, 2'd1, 0, 32'h0000_2006, 32'h0000_ABCD, 0, 0, 0, 0, r, w);
    checks++;
    if (w !== 32'hABCD_2222) begin errors++; $display("FAIL half_store const: got %h want abcd2222", w); end
    mem_m[32'h0000_3000] = 32'h0000_0000;
    do_access("byte_store_wait", 1, 2'd0, 0, 32'h0000_3001, 32'h0000_005A, 3, 3, 1, 0, r, w);
    checks++;
    if (w !== 32'h0000_5A00) begin errors++; $display("FAIL byte_store_wait const: got %h want 00005a00", w); end
    do_access("mis_word", 0, 2'd2, 0, 32'h0000_5002, '0, 0, 0, 0, 0, r, w);
    do_access("mis_half", 0, 2'd1, 1, 32'h0000_5003, '0, 0, 0, 0, 0, r, w);
    do_access("illegal_op", 1, 2'd3, 0, 32'h0000_5000, 32'h1234_5678, 0, 0, 0, 0, r, w);
    do_access("word_store", 1, 2'd2, 0, 32'h0000_5004, 32'hCAFE_F00D, 0, 2, 0, 0, r, w);
    do_access("word_reload", 0, 2'd2, 0, 32'h0000_5004, '0, 1, 0, 0, 0, r, w);
    checks++;
    if (r !== 32'hCAFE_F00D) begin errors++; $display("FAIL word_reload const: got %h want cafef00d", r); end
  endtask

  task automatic test_ack_ignored();
    bit bad;
    bad = 0;
    mem_ack = 1'b1;
    repeat (3) begin
      tick();
      if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1;
    end
    mem_ack = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL idle_ack: got activity want none"); end
  endtask

  task automatic test_random();
    logic [31:0] r, w;
    for (int i = 0; i < 60; i++) begin
      do_access("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'h0000_4000 | ($urandom & 32'h3F), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, r, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, w, a, d;
    for (int i = 0; i < 6; i++) begin
      a = 32'h0000_4100 + 32'(4 * i);
      d = $urandom;
      do_access("b2b_store", 1, 2'd2, 0, a, d, 0, 0, 0, 0, r, w);
      do_access("b2b_byte", 1, 2'd0, 0, a + 32'(i % 4), $urandom, 0, 0, 0, 0, r, w);
      do_access("b2b_load", 0, 2'(i % 3), 1'(i % 2), a + ((i % 3 == 1) ? 32'd2 : 32'd0), '0, 0, 0, 0, 0, r, w);
    end
  endtask

  task automatic test_reset_mid();
    int n_resp;
    if (!mem_m.exists(32'h0000_6000)) mem_m[32'h0000_6000] = $urandom;
    req_valid = 1'b1; req_wr = 1'b1; req_op = 2'd0; req_ext = 1'b0;
    req_addr = 32'h0000_6001; req_wdata = 32'h0000_00A5;
    tick();
    req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = mem_m[32'h0000_6000];
    tick();
    mem_ack = 1'b0;
    repeat (5) tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL rst_mid wr wait: got req %b we %b want 1 1", mem_req, mem_we);
    end
    rst = 1'b1;
    #1;
    checks += 3;
    if (mem_req !== 1'b0)    begin errors++; $display("FAIL rst_mid mem_req: got %b want 0", mem_req); end
    if (req_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid req_ready: got %b want 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid resp_valid: got %b want 0", resp_valid); end
    tick();
    rst = 1'b0;
    n_resp = 0;
    repeat (4) begin
      tick();
      if (resp_valid !== 1'b0) n_resp++;
    end
    checks++;
    if (n_resp != 0) begin errors++; $display("FAIL rst_mid late resp: got %0d want 0", n_resp); end
  endtask

`ifdef MAU_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] r, w;
    do_access("tmo_load", 0, 2'd2, 0, 32'h0000_7000, '0, 1000, 0, 0, 1, r, w);
    do_access("tmo_rmw", 1, 2'd0, 0, 32'h0000_7001, 32'h0000_0077, 1000, 0, 0, 1, r, w);
    do_access("tmo_wstore", 1, 2'd2, 0, 32'h0000_7004, 32'h0BAD_0BAD, 0, 1000, 0, 1, r, w);
    do_access("tmo_after", 0, 2'd2, 0, 32'h0000_7000, '0, 0, 0, 0, 0, r, w);
  endtask
`else
  task automatic test_no_ack_hold();
    int n_hold;
    req_valid = 1'b1; req_wr = 1'b0; req_op = 2'd2; req_ext = 1'b0;
    req_addr = 32'h0000_7000; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    n_hold = 0;
    repeat (40) begin
      if (mem_req === 1'b1 && resp_valid === 1'b0) n_hold++;
      tick();
    end
    checks++;
    if (n_hold != 40) begin errors++; $display("FAIL no_ack hold: got %0d want 40", n_hold); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ack_ignored();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef MAU_TIMEOUT_EN
    test_timeout();
`else
    test_no_ack_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
